// File: rtl/ledpi_pkg.sv
// ============================================================================
// Module  : ledpi_pkg
// Brief   : Shared geometry, command and state definitions for the HUB75 path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ledpi_pkg;

    localparam int COLS = 64;
    localparam int ROWS = 32;
    localparam logic [7:0] CMD_FRAME = 8'hA5;

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int ADDR_W = ROW_W + COL_W + 2;
    localparam int FRAME_BYTES = COLS * ROWS * 3;

    localparam logic [1:0] COLOR_R = 2'd0;
    localparam logic [1:0] COLOR_G = 2'd1;
    localparam logic [1:0] COLOR_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PIXELS    = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } fl_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_addr_counter.sv
// ============================================================================
// Module  : fb_addr_counter
// Brief   : Row/column/color frame-memory address counter; color skips code 3.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_addr_counter
    import ledpi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [1:0]       r_color;

    assign addr = {r_row, r_col, r_color};
    assign last = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1)) &&
                  (r_color == COLOR_B);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_row   <= '0;
            r_col   <= '0;
            r_color <= COLOR_R;
        end else if (inc) begin
            if (r_color == COLOR_B) begin
                r_color <= COLOR_R;
                if (r_col == COL_W'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_color <= r_color + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_loader.sv
// ============================================================================
// Module  : frame_loader
// Brief   : Parses SPI frame packets into the back frame buffer and swaps
//           buffers on scan end-of-frame. Define FRAME_LOADER_CHECKSUM_EN to
//           require a trailing modulo-256 pixel checksum byte.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_loader
    import ledpi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              disp_frame_end,
    output logic              fb_we,
    output logic              fb_buf,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              disp_buf,
    output logic              frame_swapped,
    output logic              err_short,
    output logic              err_busy,
    output logic              busy
);

    fl_state_t         r_state;
    logic              r_disp_buf;
    logic              r_cs_rose;
    logic              w_pix_byte;
    logic              w_cnt_clear;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic              w_cnt_last;

`ifdef FRAME_LOADER_CHECKSUM_EN
    logic              r_sum_phase;
    logic [7:0]        r_sum;
    assign w_pix_byte = (r_state == ST_PIXELS) && rx_valid && !r_sum_phase;
`else
    assign w_pix_byte = (r_state == ST_PIXELS) && rx_valid;
`endif

    assign w_cnt_clear = (r_state == ST_IDLE) && rx_valid && !cs_n &&
                         (rx_data == CMD_FRAME);
    assign busy        = (r_state == ST_PIXELS) || (r_state == ST_WAIT_SWAP);
    assign disp_buf    = r_disp_buf;

    fb_addr_counter u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_cnt_clear),
        .inc   (w_pix_byte),
        .addr  (w_cnt_addr),
        .last  (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_disp_buf    <= 1'b0;
            r_cs_rose     <= 1'b0;
            fb_we         <= 1'b0;
            fb_buf        <= 1'b0;
            fb_addr       <= '0;
            fb_wdata      <= '0;
            frame_swapped <= 1'b0;
            err_short     <= 1'b0;
            err_busy      <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            r_sum_phase   <= 1'b0;
            r_sum         <= '0;
`endif
        end else begin
            fb_we         <= 1'b0;
            frame_swapped <= 1'b0;
            err_short     <= 1'b0;
            err_busy      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (w_cnt_clear) begin
                            r_state <= ST_PIXELS;
`ifdef FRAME_LOADER_CHECKSUM_EN
                            r_sum_phase <= 1'b0;
                            r_sum       <= '0;
`endif
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_PIXELS: begin
                    if (w_pix_byte) begin
                        fb_we    <= 1'b1;
                        fb_buf   <= ~r_disp_buf;
                        fb_addr  <= w_cnt_addr;
                        fb_wdata <= rx_data;
                    end
`ifdef FRAME_LOADER_CHECKSUM_EN
                    if (w_pix_byte)
                        r_sum <= r_sum + rx_data;
                    if (w_pix_byte && w_cnt_last) begin
                        r_sum_phase <= 1'b1;
                    end else if (r_sum_phase && rx_valid) begin
                        if (rx_data == r_sum) begin
                            r_state   <= ST_WAIT_SWAP;
                            r_cs_rose <= cs_n;
                        end else begin
                            r_state   <= ST_IDLE;
                            err_short <= 1'b1;
                        end
                    end else if (cs_n) begin
                        r_state   <= ST_IDLE;
                        err_short <= 1'b1;
                    end
`else
                    // A byte landing with the cs_n rise still counts; only a
                    // rise that leaves the frame incomplete is an abort.
                    if (w_pix_byte && w_cnt_last) begin
                        r_state   <= ST_WAIT_SWAP;
                        r_cs_rose <= cs_n;
                    end else if (cs_n) begin
                        r_state   <= ST_IDLE;
                        err_short <= 1'b1;
                    end
`endif
                end
                ST_DRAIN: begin
                    if (cs_n)
                        r_state <= ST_IDLE;
                end
                ST_WAIT_SWAP: begin
                    if (disp_frame_end) begin
                        r_disp_buf    <= ~r_disp_buf;
                        frame_swapped <= 1'b1;
                        r_state       <= cs_n ? ST_IDLE : ST_DRAIN;
                    end else if (cs_n) begin
                        r_cs_rose <= 1'b1;
                    end else if (rx_valid) begin
                        // Only the first byte of a fresh cs_n window is a command.
                        err_busy  <= r_cs_rose && (rx_data == CMD_FRAME);
                        r_cs_rose <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_loader.sv
// ============================================================================
// Module  : tb_frame_loader
// Brief   : Scoreboard bench for frame_loader (honours FRAME_LOADER_CHECKSUM_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_loader;

    localparam int NCOLS  = 64;
    localparam int NROWS  = 32;
    localparam int NBYTES = NCOLS * NROWS * 3;

    logic        clk = 1'b0;
    logic        rst_n, cs_n, rx_valid, disp_frame_end;
    logic [7:0]  rx_data;
    logic        fb_we, fb_buf, disp_buf, frame_swapped, err_short, err_busy, busy;
    logic [12:0] fb_addr;
    logic [7:0]  fb_wdata;

    always #5 clk = ~clk;

    frame_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cs_n           (cs_n),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .disp_frame_end (disp_frame_end),
        .fb_we          (fb_we),
        .fb_buf         (fb_buf),
        .fb_addr        (fb_addr),
        .fb_wdata       (fb_wdata),
        .disp_buf       (disp_buf),
        .frame_swapped  (frame_swapped),
        .err_short      (err_short),
        .err_busy       (err_busy),
        .busy           (busy)
    );

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        logic        bufi;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  tests = 0, fails = 0;
    int  n_we = 0, n_swap = 0, n_short = 0, n_busy = 0;
    bit  model_disp = 1'b0;
    int  w0, s0, e0, b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            n_we++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
                check("wr_data", 32'(fb_wdata), 32'(mon_e.data));
                check("wr_buf", 32'(fb_buf), 32'(mon_e.bufi));
            end
        end
        if (frame_swapped === 1'b1) n_swap++;
        if (err_short === 1'b1) n_short++;
        if (err_busy === 1'b1) n_busy++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit cs_rise, input bit dfe);
        rx_valid = 1'b1;
        rx_data = b;
        if (cs_rise) cs_n = 1'b1;
        disp_frame_end = dfe;
        tick();
        rx_valid = 1'b0;
        disp_frame_end = 1'b0;
        if ($urandom_range(0, 7) == 0) tick();
    endtask

    // Pixel i lands at row i/(3*COLS), column (i/3)%COLS, color i%3.
    task automatic send_frame(input logic [7:0] cmd, input int n, input bit idx_data,
                              input bit expect_wr, input bit bad_sum,
                              input bit last_cs, input bit last_dfe);
        logic [7:0] b;
        logic [7:0] sum;
        bit         has_sum;
        bit         fin;
        sum = 8'd0;
        has_sum = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
        has_sum = (n == NBYTES);
`endif
        cs_n = 1'b0;
        tick();
        send_byte(cmd, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = idx_data ? 8'(i % 256) : 8'($urandom);
            if (expect_wr)
                exp_q.push_back('{addr: 13'((i / (NCOLS * 3)) * 256 + ((i / 3) % NCOLS) * 4 + (i % 3)),
                                  data: b, bufi: ~model_disp});
            sum = sum + b;
            fin = (i == n - 1) && !has_sum;
            send_byte(b, fin && last_cs, fin && last_dfe);
        end
        if (has_sum)
            send_byte(sum + {7'd0, bad_sum}, last_cs, last_dfe);
    endtask

    task automatic pulse_dfe();
        disp_frame_end = 1'b1;
        tick();
        disp_frame_end = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; disp_frame_end = 1'b0;
        tick(); tick(); tick();
        check("rst_fb_we", 32'(fb_we), 0);
        check("rst_disp_buf", 32'(disp_buf), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", {29'd0, frame_swapped, err_short, err_busy}, 0);
        check("rst_fb_addr", 32'(fb_addr), 0);
        rst_n = 1'b1;
        tick();

        // Full frame, swap while cs_n still low, then drained bytes
        w0 = n_we; s0 = n_swap;
        send_frame(8'hA5, NBYTES, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("t1_writes", n_we - w0, NBYTES);
        check("t1_busy_wait", 32'(busy), 1);
        check("t1_disp_before", 32'(disp_buf), 0);
        pulse_dfe();
        model_disp = ~model_disp;
        check("t1_swap_pulse", 32'(frame_swapped), 1);
        check("t1_disp_after", 32'(disp_buf), 1);
        check("t1_busy_drain", 32'(busy), 0);
        for (int i = 0; i < 5; i++) send_byte(8'hA5, 1'b0, 1'b0);
        cs_n = 1'b1;
        tick(); tick();
        check("t1_swaps", n_swap - s0, 1);
        check("t1_drain_writes", n_we - w0, NBYTES);

        // Short frame
        w0 = n_we; s0 = n_swap; e0 = n_short;
        send_frame(8'hA5, 100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cs_n = 1'b1;
        tick();
        check("t2_err_short_pulse", 32'(err_short), 1);
        tick();
        check("t2_writes", n_we - w0, 100);
        check("t2_err_count", n_short - e0, 1);
        check("t2_busy", 32'(busy), 0);
        pulse_dfe();
        tick();
        check("t2_no_swap", n_swap - s0, 0);
        check("t2_disp", 32'(disp_buf), 32'(model_disp));

        // Wrong command, then a frame whose last byte coincides with cs_n rise
        w0 = n_we; e0 = n_short; b0 = n_busy;
        send_frame(8'h5A, 50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cs_n = 1'b1;
        tick(); tick();
        check("t3_no_writes", n_we - w0, 0);
        check("t3_no_errs", (n_short - e0) + (n_busy - b0), 0);
        s0 = n_swap;
        send_frame(8'hA5, NBYTES, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("t3_busy_wait", 32'(busy), 1);
        check("t3_no_short", n_short - e0, 0);
        pulse_dfe();
        model_disp = ~model_disp;
        tick();
        check("t3_disp", 32'(disp_buf), 32'(model_disp));
        check("t3_swaps", n_swap - s0, 1);
        check("t3_idle", 32'(busy), 0);

        // Last pixel with disp_frame_end, then a busy command
        s0 = n_swap; b0 = n_busy;
        send_frame(8'hA5, NBYTES, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("t4_no_early_swap", n_swap - s0, 0);
        check("t4_busy", 32'(busy), 1);
        cs_n = 1'b1;
        tick();
        w0 = n_we;
        send_frame(8'hA5, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cs_n = 1'b1;
        tick();
        check("t4_err_busy", n_busy - b0, 1);
        check("t4_no_writes", n_we - w0, 0);
        check("t4_still_busy", 32'(busy), 1);
        check("t4_disp_held", 32'(disp_buf), 32'(model_disp));
        pulse_dfe();
        model_disp = ~model_disp;
        tick();
        check("t4_swaps", n_swap - s0, 1);
        check("t4_disp", 32'(disp_buf), 32'(model_disp));

        // Reset mid-frame, then a fresh frame
        send_frame(8'hA5, 3000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_disp = 1'b0;
        check("t5_fb_we", 32'(fb_we), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_disp", 32'(disp_buf), 0);
        cs_n = 1'b1;
        tick();
        s0 = n_swap;
        send_frame(8'hA5, NBYTES, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cs_n = 1'b1;
        tick();
        pulse_dfe();
        model_disp = ~model_disp;
        tick();
        check("t5_swaps", n_swap - s0, 1);
        check("t5_disp_after", 32'(disp_buf), 1);

`ifdef FRAME_LOADER_CHECKSUM_EN
        // Checksum off by one is rejected
        s0 = n_swap; e0 = n_short;
        send_frame(8'hA5, NBYTES, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cs_n = 1'b1;
        tick();
        check("t6_err_short", n_short - e0, 1);
        check("t6_busy", 32'(busy), 0);
        pulse_dfe();
        tick();
        check("t6_no_swap", n_swap - s0, 0);
        check("t6_disp", 32'(disp_buf), 32'(model_disp));
`endif

        tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
